// File: rtl/datapath_pkg.sv
// ============================================================================
// Module   : datapath_pkg
// Purpose  : Shared ALU opcodes, status bit positions and controlWord layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

    localparam logic [2:0] FS_AND   = 3'b000;
    localparam logic [2:0] FS_OR    = 3'b001;
    localparam logic [2:0] FS_ADD   = 3'b010;
    localparam logic [2:0] FS_XOR   = 3'b011;
    localparam logic [2:0] FS_LSL   = 3'b100;
    localparam logic [2:0] FS_LSR   = 3'b101;
    localparam logic [2:0] FS_PASSB = 3'b110;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    localparam int CW_DA     = 0;
    localparam int CW_SA     = 1;
    localparam int CW_SB     = 2;
    localparam int CW_FS     = 3;
    localparam int CW_REGW   = 4;
    localparam int CW_RAMW   = 5;
    localparam int CW_SELALU = 6;
    localparam int CW_SELK   = 7;

    // LSB position of a controlWord field; layout is {DA, SA, SB, FS[4:0], regW, ramW, selALU, selK}
    function automatic int cw_lsb(input int reg_addr_w, input int field);
        case (field)
            CW_DA:     return 9 + 2 * reg_addr_w;
            CW_SA:     return 9 + reg_addr_w;
            CW_SB:     return 9;
            CW_FS:     return 4;
            CW_REGW:   return 3;
            CW_RAMW:   return 2;
            CW_SELALU: return 1;
            default:   return 0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_param.sv
// ============================================================================
// Module   : alu_param
// Purpose  : Combinational parametrised ALU producing result and {V,C,N,Z}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_param
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [4:0]            fs,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            status
);

    localparam int C_SH_W = $clog2(DATA_WIDTH);
    localparam int C_MSB  = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_b   = fs[1] ? ~b : b;
    assign w_sum = {1'b0, a} + {1'b0, w_b} + {{DATA_WIDTH{1'b0}}, fs[0]};

    always_comb begin
        result = '0;
        status = '0;
        case (fs[4:2])
            FS_AND: result = a & w_b;
            FS_OR:  result = a | w_b;
            FS_ADD: begin
                result       = w_sum[C_MSB:0];
                status[ST_C] = w_sum[DATA_WIDTH];
                status[ST_V] = (a[C_MSB] == w_b[C_MSB]) && (w_sum[C_MSB] != a[C_MSB]);
            end
            FS_XOR: result = a ^ w_b;
            FS_LSL: result = a << w_b[C_SH_W-1:0];
            FS_LSR: result = a >> w_b[C_SH_W-1:0];
            default: result = w_b;
        endcase
        status[ST_N] = result[C_MSB];
        status[ST_Z] = (result == '0);
    end

endmodule

`default_nettype wire

// File: rtl/datapath_reg_alu_pipe.sv
// ============================================================================
// Module   : datapath_reg_alu_pipe
// Purpose  : Two-stage register-file / ALU / RAM datapath (EX then WB).
//            Macro DATAPATH_BYPASS_EN enables the WB->EX operand bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module datapath_reg_alu_pipe
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int RAM_ADDR_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid,
    input  logic [3*REG_ADDR_W+8:0]   controlWord,
    input  logic [DATA_WIDTH-1:0]     K,
    output logic [3:0]                status,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      data_valid
);

    localparam int C_NREG      = 2 ** REG_ADDR_W;
    localparam int C_RAM_DEPTH = 2 ** RAM_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] C_ZERO_REG = '1;

    localparam int C_DA_LSB = cw_lsb(REG_ADDR_W, CW_DA);
    localparam int C_SA_LSB = cw_lsb(REG_ADDR_W, CW_SA);
    localparam int C_SB_LSB = cw_lsb(REG_ADDR_W, CW_SB);
    localparam int C_FS_LSB = cw_lsb(REG_ADDR_W, CW_FS);

    logic [REG_ADDR_W-1:0] w_da, w_sa, w_sb;
    logic [4:0]            w_fs;
    logic                  w_regw, w_ramw, w_selalu, w_selk;

    assign w_da     = controlWord[C_DA_LSB +: REG_ADDR_W];
    assign w_sa     = controlWord[C_SA_LSB +: REG_ADDR_W];
    assign w_sb     = controlWord[C_SB_LSB +: REG_ADDR_W];
    assign w_fs     = controlWord[C_FS_LSB +: 5];
    assign w_regw   = controlWord[cw_lsb(REG_ADDR_W, CW_REGW)];
    assign w_ramw   = controlWord[cw_lsb(REG_ADDR_W, CW_RAMW)];
    assign w_selalu = controlWord[cw_lsb(REG_ADDR_W, CW_SELALU)];
    assign w_selk   = controlWord[cw_lsb(REG_ADDR_W, CW_SELK)];

    logic [DATA_WIDTH-1:0] r_regs [C_NREG];
    logic [DATA_WIDTH-1:0] r_ram  [C_RAM_DEPTH];

    logic [REG_ADDR_W-1:0] r_wb_da;
    logic                  r_wb_regw;
    logic [DATA_WIDTH-1:0] r_wb_result;
    logic [3:0]            r_status;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_valid;

    logic                  w_byp_a, w_byp_b;
    logic [DATA_WIDTH-1:0] w_a, w_sb_val, w_b;
    logic [DATA_WIDTH-1:0] w_alu_result, w_ram_rd, w_result;
    logic [3:0]            w_alu_status;
    logic [RAM_ADDR_W-1:0] w_addr;

`ifdef DATAPATH_BYPASS_EN
    assign w_byp_a = r_wb_regw && (r_wb_da == w_sa);
    assign w_byp_b = r_wb_regw && (r_wb_da == w_sb);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    // Zero-register check comes first so it is never overridden by the bypass
    assign w_a      = (w_sa == C_ZERO_REG) ? '0 : (w_byp_a ? r_wb_result : r_regs[w_sa]);
    assign w_sb_val = (w_sb == C_ZERO_REG) ? '0 : (w_byp_b ? r_wb_result : r_regs[w_sb]);
    assign w_b      = w_selk ? K : w_sb_val;

    alu_param #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a      (w_a),
        .b      (w_b),
        .fs     (w_fs),
        .result (w_alu_result),
        .status (w_alu_status)
    );

    assign w_addr   = w_alu_result[RAM_ADDR_W-1:0];
    assign w_ram_rd = r_ram[w_addr];
    assign w_result = w_selalu ? w_alu_result : w_ram_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < C_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_wb_regw && (r_wb_da != C_ZERO_REG)) begin
            r_regs[r_wb_da] <= r_wb_result;
        end
    end

    // RAM has no reset; stores use the register value of SB even when selK=1
    always_ff @(posedge clock) begin
        if (!reset && valid && w_ramw) begin
            r_ram[w_addr] <= w_sb_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_da      <= '0;
            r_wb_regw    <= 1'b0;
            r_wb_result  <= '0;
            r_status     <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else if (valid) begin
            r_wb_da      <= w_da;
            r_wb_regw    <= w_regw;
            r_wb_result  <= w_result;
            r_status     <= w_alu_status;
            r_data       <= w_result;
            r_data_valid <= 1'b1;
        end else begin
            r_wb_regw    <= 1'b0;
            r_data_valid <= 1'b0;
        end
    end

    assign status     = r_status;
    assign data       = r_data;
    assign data_valid = r_data_valid;

endmodule

`default_nettype wire

// File: tb/tb_datapath_reg_alu_pipe.sv
// ============================================================================
// Module   : tb_datapath_reg_alu_pipe
// Purpose  : Scoreboard bench for datapath_reg_alu_pipe (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datapath_reg_alu_pipe;

    localparam int DW  = 64;
    localparam int CWW = 24;
    localparam logic [4:0] ZR    = 5'd31;
    localparam logic [4:0] F_OR  = 5'b00100;
    localparam logic [4:0] F_ADD = 5'b01000;
    localparam logic [4:0] F_SUB = 5'b01011;
    localparam logic [4:0] F_XOR = 5'b01100;
    localparam logic [4:0] F_LSL = 5'b10000;

    logic           clock = 1'b0;
    logic           reset;
    logic           valid;
    logic [CWW-1:0] controlWord;
    logic [DW-1:0]  K;
    logic [3:0]     status;
    logic [DW-1:0]  data;
    logic           data_valid;

    datapath_reg_alu_pipe dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .controlWord (controlWord),
        .K           (K),
        .status      (status),
        .data        (data),
        .data_valid  (data_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    st;
        string         name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   gap      = 1;
    logic [DW-1:0] exp_b2b;

    function automatic logic [CWW-1:0] cw(input logic [4:0] da, input logic [4:0] sa,
                                          input logic [4:0] sb, input logic [4:0] fs,
                                          input logic regw, input logic ramw,
                                          input logic selalu, input logic selk);
        return {da, sa, sb, fs, regw, ramw, selalu, selk};
    endfunction

    task automatic idle();
        valid       = 1'b0;
        controlWord = '0;
        K           = '0;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input string nm, input logic [CWW-1:0] c, input logic [DW-1:0] k,
                         input logic [DW-1:0] ed, input logic [3:0] es);
        valid       = 1'b1;
        controlWord = c;
        K           = k;
        q.push_back('{ed, es, nm});
        @(posedge clock);
        #1;
        repeat (gap) idle();
    endtask

    task automatic dcheck(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every data_valid output is matched against the oldest expectation
    always @(negedge clock) begin
        if (data_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: data=%h with no pending op", data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data !== e.data || status !== e.st) begin
                    failures++;
                    $display("FAIL %s: data=%h status=%b expected data=%h status=%b",
                             e.name, data, status, e.data, e.st);
                end
            end
        end
    end

    initial begin
`ifdef DATAPATH_BYPASS_EN
        gap     = 0;
        exp_b2b = 64'd63;
`else
        gap     = 1;
        exp_b2b = 64'd24;
`endif
        reset       = 1'b1;
        valid       = 1'b0;
        controlWord = '0;
        K           = '0;
        repeat (2) @(posedge clock);
        #1;
        dcheck("reset_dv", {63'd0, data_valid}, 64'd0);
        dcheck("reset_data", data, 64'd0);
        dcheck("reset_status", {60'd0, status}, 64'd0);
        reset = 1'b0;

        // Main program
        issue("r5",   cw(5,  ZR, 0,  F_OR,  1, 0, 1, 1), 64'd24, 64'd24,  4'b0000);
        issue("r7",   cw(7,  ZR, 0,  F_OR,  1, 0, 1, 1), 64'd39, 64'd39,  4'b0000);
        issue("add",  cw(1,  5,  7,  F_ADD, 1, 0, 1, 0), 64'd0,  64'd63,  4'b0000);
        issue("xor",  cw(30, 1,  5,  F_XOR, 1, 0, 1, 0), 64'd0,  64'd39,  4'b0000);
        issue("lsl",  cw(17, 30, 0,  F_LSL, 1, 0, 1, 1), 64'd2,  64'd156, 4'b0000);
        issue("st",   cw(0,  7,  17, F_OR,  0, 1, 1, 1), 64'd0,  64'd39,  4'b0000);
        issue("ld",   cw(0,  7,  0,  F_OR,  1, 0, 0, 1), 64'd0,  64'd156, 4'b0000);
        issue("addi", cw(0,  0,  0,  F_ADD, 1, 0, 1, 1), 64'd4,  64'd160, 4'b0000);

        // Flag corners
        issue("sub",   cw(2, 5,  5, F_SUB, 1, 0, 1, 0), 64'd0, 64'd0, 4'b0101);
        issue("ldmax", cw(3, ZR, 0, F_OR,  1, 0, 1, 1), 64'h7FFF_FFFF_FFFF_FFFF,
              64'h7FFF_FFFF_FFFF_FFFF, 4'b0000);
        issue("ovf",   cw(4, 3,  0, F_ADD, 1, 0, 1, 1), 64'd1,
              64'h8000_0000_0000_0000, 4'b1010);

        // Zero register
        issue("wzero", cw(ZR, ZR, 0, F_OR, 1, 0, 1, 1), 64'd55, 64'd55, 4'b0000);
        issue("rzero", cw(0,  ZR, 0, F_OR, 0, 0, 1, 1), 64'd0,  64'd0,  4'b0001);
        issue("r5chk", cw(0,  5,  0, F_OR, 0, 0, 1, 1), 64'd0,  64'd24, 4'b0000);
        issue("r7chk", cw(0,  7,  0, F_OR, 0, 0, 1, 1), 64'd0,  64'd39, 4'b0000);

        // Non-valid cycles carrying writes must change nothing
        valid       = 1'b0;
        controlWord = cw(5, ZR, 5, F_OR, 1, 1, 1, 1);
        K           = 64'd39;
        repeat (2) @(posedge clock);
        #1;
        dcheck("hold_dv", {63'd0, data_valid}, 64'd0);
        dcheck("hold_data", data, 64'd39);
        dcheck("hold_status", {60'd0, status}, 64'd0);
        issue("r5hold", cw(0, 5, 0, F_OR, 0, 0, 1, 1), 64'd0, 64'd24,  4'b0000);
        issue("m39",    cw(0, 7, 0, F_OR, 0, 0, 0, 1), 64'd0, 64'd156, 4'b0000);

        // Reset while the R1 write is still in WB
        valid       = 1'b1;
        controlWord = cw(1, 5, 7, F_ADD, 1, 0, 1, 0);
        K           = '0;
        q.push_back('{64'd63, 4'b0000, "add_pre_rst"});
        @(posedge clock);
        #1;
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clock);
        #1;
        dcheck("rst2_dv", {63'd0, data_valid}, 64'd0);
        dcheck("rst2_data", data, 64'd0);
        dcheck("rst2_status", {60'd0, status}, 64'd0);
        reset = 1'b0;
        issue("r1_after_rst", cw(0, 1,  0, F_OR, 0, 0, 1, 1), 64'd0,  64'd0,   4'b0001);
        issue("ram_kept",     cw(0, ZR, 0, F_OR, 0, 0, 0, 1), 64'd39, 64'd156, 4'b0000);

        // Back-to-back dependency with no gaps
        gap = 0;
        issue("b2b_r5",  cw(5, ZR, 0, F_OR,  1, 0, 1, 1), 64'd24, 64'd24, 4'b0000);
        issue("b2b_r7",  cw(7, ZR, 0, F_OR,  1, 0, 1, 1), 64'd39, 64'd39, 4'b0000);
        issue("b2b_add", cw(1, 5,  7, F_ADD, 1, 0, 1, 0), 64'd0,  exp_b2b, 4'b0000);
        idle();
        issue("b2b_r1",  cw(0, 1,  0, F_OR,  0, 0, 1, 1), 64'd0,  exp_b2b, 4'b0000);

        repeat (3) idle();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d outputs missing, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/datapath_reg_alu_pipe.md
Name: datapath_reg_alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle register-file/ALU/RAM datapath.
- Executes one control word per valid cycle: register read, ALU, RAM access in stage EX; register write-back in stage WB.
- Adds configurable data width, register count and RAM depth, a valid qualifier, registered status and data outputs, and an EX←WB bypass.
- Sits under the future control unit, which drives controlWord/K.

Parameters:
- DATA_WIDTH, 64, datapath width in bits.
- REG_ADDR_W, 5, register address width; 2**REG_ADDR_W registers; highest index is the hard-wired zero register.
- RAM_ADDR_W, 8, RAM word-address width; RAM is 2**RAM_ADDR_W x DATA_WIDTH.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid  in  1  controlWord/K are valid this cycle.
- controlWord  in  3*REG_ADDR_W+9  {DA, SA, SB, FS[4:0], regW, ramW, selALU, selK}, MSB first.
- K  in  DATA_WIDTH  immediate operand.
- status  out  4  {V, C, N, Z} of the last valid ALU op, registered.
- data  out  DATA_WIDTH  result of the last valid op (ALU result or RAM load), registered.
- data_valid  out  1  data/status updated by a valid op on the previous edge.

Behaviour:
- Reset: on a rising edge with reset=1, all registers and the WB stage clear to 0. status=0, data=0, data_valid=0. RAM contents are not cleared. A pending WB write is dropped.
- EX stage, combinational in the valid cycle:
  - A = R[SA]; B = selK ? K : R[SB]; reads of index 2**REG_ADDR_W-1 return 0.
  - ALU op FS[4:2]: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR, 11x pass B.
  - FS[1] inverts B before the op; FS[0] is carry-in for ADD (SUB = FS 01011).
  - Shift amount is B[$clog2(DATA_WIDTH)-1:0].
  - C = carry out of ADD; V = signed overflow of ADD; C = V = 0 for non-ADD ops; N = result MSB; Z = result==0.
  - RAM address = ALU result[RAM_ADDR_W-1:0], upper bits ignored. Read is asynchronous.
  - Result = selALU ? ALU result : RAM[addr].
- EX edge:
  - if valid && ramW, RAM[addr] <= R[SB]. This is the register value even when selK=1; it is bypassed if needed.
  - If valid, the WB register captures {DA, regW, result}; status and data update; data_valid <= 1.
  - If !valid, data_valid <= 0; status and data hold; the WB register's regW clears.
- WB edge: if WB regW and WB DA != zero index, R[WB DA] <= WB result. Writes to the zero register are discarded.
- Latency: result on data one edge after the valid cycle. Register file updated on the second edge.
- Hazard: an EX read of the register being written by WB that cycle returns the WB result (bypass, see Optional Feature). No stalls; back-to-back dependent ops are legal.
- Load followed by a dependent op, and RAM read-after-write to the same address in consecutive cycles: the later op observes the new value.
- valid=0: no architectural state changes.
- reset and valid both high: reset wins.

Optional Feature:
- Macro DATAPATH_BYPASS_EN.
- Defined: WB→EX bypass for SA and SB reads, including the RAM write-data path. Zero-register reads are never bypassed.
- Undefined: no bypass. EX reads return the pre-write register value. Software must insert one non-valid cycle or an independent op between dependent ops.

Decomposition:
- Package datapath_pkg:
  - FS op localparams (FS_AND, FS_OR, FS_ADD, FS_XOR, FS_LSL, FS_LSR, FS_PASSB);
  - status bit indices;
  - a function returning controlWord field offsets from REG_ADDR_W.
- Sub-module alu_param: combinational, parametrised by DATA_WIDTH; A, B, FS in; result and status out.
- Register file, RAM and pipeline registers stay in the top module.

Test Plan:
- Program (defaults), one op per cycle, valid=1, no gaps:
  - R5<=0|24 → data=24;
  - R7<=0|39 → data=39;
  - R1<=R5+R7 → data=63;
  - R30<=R1^R5 → data=39;
  - R17<=R30<<2 → data=156;
  - M[R7]<=R17 → store;
  - R0<=M[R7] → data=156;
  - R0<=R0+4 → data=160, status Z=0 N=0 C=0 V=0.
  - This program requires DATAPATH_BYPASS_EN.
- Same program with DATAPATH_BYPASS_EN undefined and one valid=0 cycle between ops → identical data sequence. Back-to-back without gaps → R1 op yields 24, showing the stale read.
- R5-R5 (FS 01011) → data=0, Z=1, C=1. Then 0x7FFF…F+1 → N=1, V=1, C=0.
- Write 55 to the zero register, then read it via SA → data=0. Other registers unchanged.
- Assert reset in the cycle after R1<=R5+R7 issues → R1 reads 0 afterwards; status=0, data=0, data_valid=0.
- valid=0 with regW=1, ramW=1 → no register or RAM change; data_valid=0; status and data hold.
